// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: opcodes, error codes, FSM states and flag bit positions shared by the UART ALU bridge
package uart_alu_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;
  localparam logic [7:0] ERR_BAD_OP  = 8'hEE;
  localparam logic [7:0] ERR_TIMEOUT = 8'hE1;
  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, SEND, SEND_WAIT} state_t;
endpackage

// File: rtl/uart_alu_bridge_z80_alu_w.sv
// z80_alu_w: combinational WIDTH-bit Z80-style ALU producing result and flag byte
module z80_alu_w
  import uart_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags
);
  logic arith, sub, ci, ovf;
  logic [WIDTH:0] full;
  logic [4:0] half;
  logic [WIDTH-1:0] r;
  // Evaluate the op one bit wider than the operands so carry/borrow falls out of the top bit
  always_comb begin
    sub = op == OP_SUB || op == OP_SBC || op == OP_CP;
    arith = !op[2] || op == OP_CP;
    ci = (op == OP_ADC || op == OP_SBC) && cin;
    full = sub ? {1'b0, a} - {1'b0, b} - (WIDTH+1)'(ci) : {1'b0, a} + {1'b0, b} + (WIDTH+1)'(ci);
    half = sub ? {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(ci) : {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(ci);
    r = arith ? full[WIDTH-1:0] : op == OP_AND ? a & b : op == OP_XOR ? a ^ b : a | b;
    ovf = arith ? ((sub ? a[WIDTH-1] != b[WIDTH-1] : a[WIDTH-1] == b[WIDTH-1]) && r[WIDTH-1] != a[WIDTH-1]) : ~^r[7:0];
    result = op == OP_CP ? a : r;
    flags = '0;
    flags[FLAG_S] = r[WIDTH-1];
    flags[FLAG_Z] = r == '0;
    flags[FLAG_H] = arith ? half[4] : op == OP_AND;
    flags[FLAG_PV] = ovf;
    flags[FLAG_N] = sub;
    flags[FLAG_C] = arith && full[WIDTH];
  end
endmodule

// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: UART command/response front end for a Z80-style ALU; UART_ALU_BRIDGE_CHECKSUM_EN appends an XOR checksum byte
module uart_alu_bridge
  import uart_alu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 120000,
  parameter int BLINK_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       led,
  output logic [7:0] overrun_cnt
);
  localparam int NB = WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
  localparam int CK = 1;
  logic [7:0] csum_q, csum_d;
`else
  localparam int CK = 0;
`endif
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, last_idx;
  logic [3:0] op_q, op_d;
  logic [7:0] flags_q, flags_d, tx_data_q, tx_data_d, ovr_q, ovr_d, byte_sel, alu_flags;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_res;
  logic err_q, err_d, first_q, first_d, led_q, led_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blink_q, blink_d;

  z80_alu_w #(.WIDTH(WIDTH)) u_alu (
    .a(a_q), .b(b_q), .op(op_q[2:0]), .cin(op_q[3]), .result(alu_res), .flags(alu_flags)
  );

  // Pick the response byte at cnt_q: result bytes, then flags (or the lone error code), then checksum
  always_comb begin
    last_idx = 3'(err_q ? CK : NB + CK);
    byte_sel = err_q || cnt_q >= 3'(NB) ? flags_q : 8'(res_q >> {cnt_q, 3'b0});
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
    if (cnt_q == last_idx) byte_sel = csum_q;
`endif
  end

  // Frame receive, execute and response sequencing
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    flags_d = flags_q;
    err_d = err_q;
    first_d = 1'b0;
    tmo_d = tmo_q;
    tx_data_d = tx_data_q;
    tx_start = 1'b0;
    blink_d = blink_q == '0 ? '0 : blink_q - 1'b1;
    ovr_d = rx_valid && (state_q == EXEC || state_q == SEND || state_q == SEND_WAIT) && ovr_q != 8'hFF ? ovr_q + 1'b1 : ovr_q;
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      IDLE: if (rx_valid) begin
        op_d = rx_data[3:0];
        cnt_d = '0;
        tmo_d = '0;
        a_d = '0;
        b_d = '0;
        err_d = rx_data[7:4] != 4'h0;
        flags_d = ERR_BAD_OP;
        state_d = err_d ? SEND : GET_A;
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
        csum_d = rx_data;
`endif
      end
      GET_A, GET_B: if (rx_valid) begin
        tmo_d = '0;
        if (state_q == GET_A) a_d = a_q | (WIDTH'(rx_data) << {cnt_q, 3'b0});
        else b_d = b_q | (WIDTH'(rx_data) << {cnt_q, 3'b0});
        cnt_d = cnt_q == 3'(NB - 1) ? '0 : cnt_q + 1'b1;
        if (cnt_q == 3'(NB - 1)) state_d = state_q == GET_A ? GET_B : EXEC;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
        err_d = 1'b1;
        flags_d = ERR_TIMEOUT;
        cnt_d = '0;
        state_d = SEND;
      end else tmo_d = tmo_q + 1'b1;
      EXEC: begin
        res_d = alu_res;
        flags_d = alu_flags;
        cnt_d = '0;
        blink_d = BW'(BLINK_CYCLES);
        state_d = SEND;
      end
      SEND: if (!tx_busy) begin
        tx_start = 1'b1;
        tx_data_d = byte_sel;
        first_d = 1'b1;
        state_d = SEND_WAIT;
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
        csum_d = csum_q ^ byte_sel;
`endif
      end
      SEND_WAIT: if (!first_q && !tx_busy) begin
        state_d = cnt_q == last_idx ? IDLE : SEND;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    led_d = blink_d != '0;
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      flags_q <= '0;
      err_q <= 1'b0;
      first_q <= 1'b0;
      tmo_q <= '0;
      tx_data_q <= '0;
      ovr_q <= '0;
      blink_q <= '0;
      led_q <= 1'b0;
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      flags_q <= flags_d;
      err_q <= err_d;
      first_q <= first_d;
      tmo_q <= tmo_d;
      tx_data_q <= tx_data_d;
      ovr_q <= ovr_d;
      blink_q <= blink_d;
      led_q <= led_d;
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  assign tx_data = tx_data_d;
  assign led = led_q;
  assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_uart_alu_bridge.sv
// tb_uart_alu_bridge: randomized self-checking bench for uart_alu_bridge at WIDTH 8 and 16
`timescale 1ns/1ps
module tb_uart_alu_bridge;
  import uart_alu_pkg::*;
  localparam int TMO = 300;
  localparam int BLINK = 40;
`ifdef UART_ALU_BRIDGE_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rxd0, rxd1, txd0, txd1, ovr0, ovr1;
  logic rxv0, rxv1, txs0, txs1, txb0, txb1, led0, led1;
  int bc0 = 0, bc1 = 0;
  logic [7:0] cap0[$], cap1[$];
  logic [7:0] exp_q[$];
  int base[2];
  int n_run = 0, n_fail = 0;

  uart_alu_bridge #(.WIDTH(8), .TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLINK)) u8 (
    .clk(clk), .rst(rst), .rx_data(rxd0), .rx_valid(rxv0), .tx_data(txd0), .tx_start(txs0),
    .tx_busy(txb0), .led(led0), .overrun_cnt(ovr0));
  uart_alu_bridge #(.WIDTH(16), .TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLINK)) u16 (
    .clk(clk), .rst(rst), .rx_data(rxd1), .rx_valid(rxv1), .tx_data(txd1), .tx_start(txs1),
    .tx_busy(txb1), .led(led1), .overrun_cnt(ovr1));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (txs0) begin cap0.push_back(txd0); bc0 = $urandom_range(3, 9); end
    else if (bc0 > 0) bc0--;
  end
  always @(negedge clk) begin
    if (txs1) begin cap1.push_back(txd1); bc1 = $urandom_range(3, 9); end
    else if (bc1 > 0) bc1--;
  end
  always @(posedge clk) txb0 <= bc0 != 0;
  always @(posedge clk) txb1 <= bc1 != 0;

  function automatic int csize(input int d);
    return d != 0 ? cap1.size() : cap0.size();
  endfunction
  function automatic logic [7:0] cap_at(input int d, input int i);
    return d != 0 ? cap1[i] : cap0[i];
  endfunction
  function automatic logic txs_of(input int d);
    return d != 0 ? txs1 : txs0;
  endfunction
  function automatic logic led_of(input int d);
    return d != 0 ? led1 : led0;
  endfunction
  function automatic int st_of(input int d);
    return d != 0 ? int'(u16.state_q) : int'(u8.state_q);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_csum(input logic [7:0] opc);
    logic [7:0] x;
    x = opc;
    foreach (exp_q[i]) x ^= exp_q[i];
    if (CK) exp_q.push_back(x);
  endtask

  // Reference: expected response bytes from plain integer arithmetic
  task automatic model(input int w, input logic [7:0] opc, input longint a, input longint b);
    longint m, h, ci, full, sa, sb, s, r;
    int op;
    bit sub, arith, hc, cy, ovf;
    exp_q.delete();
    m = longint'(1) << w;
    h = m / 2;
    full = 0;
    s = 0;
    if (opc[7:4] != 4'h0) exp_q.push_back(ERR_BAD_OP);
    else begin
      op = int'(opc[2:0]);
      sub = op == 2 || op == 3 || op == 7;
      arith = op < 4 || op == 7;
      ci = (op == 1 || op == 3) ? longint'(opc[3]) : 0;
      sa = a >= h ? a - m : a;
      sb = b >= h ? b - m : b;
      if (!arith) begin
        r = op == 4 ? (a & b) : op == 5 ? (a ^ b) : (a | b);
        hc = op == 4;
        cy = 0;
        ovf = ($countones(r & 255) % 2) == 0;
      end else if (sub) begin
        full = a - b - ci;
        cy = full < 0;
        hc = (a % 16) - (b % 16) - ci < 0;
        s = sa - sb - ci;
      end else begin
        full = a + b + ci;
        cy = full >= m;
        hc = (a % 16) + (b % 16) + ci >= 16;
        s = sa + sb + ci;
      end
      if (arith) begin
        r = (full + m) % m;
        ovf = s >= h || s < -h;
      end
      for (int i = 0; i < w / 8; i++) exp_q.push_back(8'(((op == 7 ? a : r) >> (8 * i)) & 255));
      exp_q.push_back({r >= h, r == 0, 1'b0, hc, 1'b0, ovf, sub, cy});
    end
    add_csum(opc);
  endtask

  task automatic put(input int d, input logic [7:0] v);
    @(negedge clk);
    if (d != 0) begin rxd1 = v; rxv1 = 1'b1; end
    else begin rxd0 = v; rxv0 = 1'b1; end
    @(negedge clk);
    rxv0 = 1'b0;
    rxv1 = 1'b0;
  endtask

  task automatic collect(input int d, input string tag);
    int t;
    t = 0;
    while (csize(d) - base[d] < exp_q.size() && t < 3000) begin @(negedge clk); t++; end
    repeat (14) @(negedge clk);
    chk({tag, "_len"}, 32'(csize(d) - base[d]), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base[d] + i < csize(d); i++)
      chk({tag, "_byte"}, 32'(cap_at(d, base[d] + i)), 32'(exp_q[i]));
    chk({tag, "_idle"}, 32'(st_of(d)), 32'(IDLE));
    base[d] = csize(d);
  endtask

  task automatic frame(input int d, input logic [7:0] opc, input longint a, input longint b,
                       input int inj, input bit tim, input string tag);
    int nb, t;
    nb = d != 0 ? 2 : 1;
    model(8 * nb, opc, a, b);
    put(d, opc);
    if (opc[7:4] == 4'h0)
      for (int i = 0; i < 2 * nb; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        put(d, 8'((i < nb ? a : b) >> (8 * (i % nb))));
      end
    if (tim) begin
      chk({tag, "_led_pre"}, 32'(led_of(d)), 0);
      @(negedge clk);
      chk({tag, "_start_lat"}, 32'(txs_of(d)), 1);
      chk({tag, "_led_exec"}, 32'(led_of(d)), 1);
    end
    if (inj > 0) begin
      t = 0;
      while (csize(d) <= base[d] && t < 500) begin @(negedge clk); t++; end
      for (int k = 0; k < inj; k++) put(d, 8'($urandom));
    end
    collect(d, tag);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, d;
    logic [7:0] opc;
    rxd0 = 0; rxd1 = 0; rxv0 = 0; rxv1 = 0;
    base[0] = 0; base[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_txs8", 32'(txs0), 0);
    chk("rst_txd8", 32'(txd0), 0);
    chk("rst_led8", 32'(led0), 0);
    chk("rst_ovr8", 32'(ovr0), 0);
    chk("rst_txs16", 32'(txs1), 0);
    chk("rst_txd16", 32'(txd1), 0);
    chk("rst_led16", 32'(led1), 0);
    chk("rst_ovr16", 32'(ovr1), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    frame(0, 8'h00, 'h3A, 'h2A, 0, 1, "add8");
    frame(0, 8'h00, 'h7F, 'h01, 0, 0, "add8_ovf");
    frame(0, 8'h02, 'h10, 'h10, 0, 0, "sub8_zero");
    frame(1, 8'h09, 'hFFFF, 'h0000, 0, 0, "adc16");
    frame(1, 8'h07, 'h1234, 'h1234, 0, 0, "cp16");
    frame(0, 8'h30, 0, 0, 0, 0, "bad_op");
    exp_q.delete();
    exp_q.push_back(ERR_TIMEOUT);
    add_csum(8'h00);
    put(0, 8'h00);
    put(0, 8'h12);
    repeat (TMO + 10) @(negedge clk);
    collect(0, "timeout");
    frame(0, 8'h05, 'h5A, 'hFF, 0, 0, "after_tmo");
    frame(1, 8'h03, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)), 3, 0, "overrun");
    chk("ovr_cnt", 32'(ovr1), 3);
    model(8, 8'h00, 'h05, 'h06);
    put(0, 8'h00);
    put(0, 8'h05);
    put(0, 8'h06);
    t = 0;
    while (csize(0) - base[0] < 2 && t < 500) begin @(negedge clk); t++; end
    rst = 1'b1;
    #1;
    chk("rst_mid_txs", 32'(txs0), 0);
    chk("rst_mid_led", 32'(led0), 0);
    chk("rst_mid_idle", 32'(st_of(0)), 32'(IDLE));
    chk("rst_mid_ovr16", 32'(ovr1), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk("rst_mid_sent", 32'(csize(0) - base[0]), 2);
    for (int i = 0; i < 2 && base[0] + i < csize(0); i++) chk("rst_mid_byte", 32'(cap_at(0, base[0] + i)), 32'(exp_q[i]));
    base[0] = csize(0);
    base[1] = csize(1);
    frame(0, 8'h01, 'hC8, 'h64, 0, 1, "after_rst");
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 1);
      opc = $urandom_range(0, 9) == 0 ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom)};
      frame(d, opc, longint'($urandom_range(0, d != 0 ? 65535 : 255)),
            longint'($urandom_range(0, d != 0 ? 65535 : 255)), 0, 0, "rand");
    end
    repeat (BLINK + 5) @(negedge clk);
    chk("led_off8", 32'(led0), 0);
    chk("led_off16", 32'(led1), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_alu_bridge.md
Name: uart_alu_bridge

Overview:
- Byte-framed command/response engine between the UART RX/TX cores and a Z80-style ALU.
- Receives an opcode byte and two WIDTH-bit operands.
- Executes one of eight Z80 ALU ops, then transmits the result bytes followed by a Z80 flag byte.
- Successor to the fixed "add 42, send sum+flags" loop: parametrised width, full op set, frame timeout, error responses, activity LED.

Parameters:
- WIDTH, 8, operand/result width in bits; multiple of 8, range 8..32.
- TIMEOUT_CYCLES, 120000, idle clocks allowed between bytes of one frame before the partial frame is discarded (10 ms at 12 MHz).
- BLINK_CYCLES, 1000000, LED on-time in clocks after each completed frame.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from uart_rx (data_out).
- rx_valid  in  1  one-cycle strobe from uart_rx (data_ready).
- tx_data  out  8  byte to uart_tx (data_in); held stable until the next tx_start.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_busy  in  1  uart_tx busy.
- led  out  1  activity indicator.
- overrun_cnt  out  8  saturating count of bytes dropped while not accepting.

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high. On reset every output is 0 and the FSM is in IDLE.
- Frame format: opcode, then A in WIDTH/8 bytes LSB first, then B in WIDTH/8 bytes LSB first.
- Opcode bits:
  - [2:0] op: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
  - [3] carry-in; used only by ADC and SBC, ignored by all other ops.
  - [7:4] must be 0.
- FSM states: IDLE, GET_A, GET_B, EXEC, SEND, SEND_WAIT.
- IDLE: on rx_valid latch the opcode.
  - Opcode[7:4] != 0: queue single error byte 0xEE, go to SEND.
  - Otherwise go to GET_A, with byte counter cleared and timeout counter cleared.
- GET_A / GET_B: each rx_valid shifts the byte into the operand at index byte_cnt.
  - After the last byte of A, go to GET_B.
  - After the last byte of B, go to EXEC.
- Timeout: any rx_valid clears the timeout counter. If the counter reaches TIMEOUT_CYCLES in GET_A or GET_B, discard the partial frame, queue error byte 0xE1, go to SEND.
- EXEC (exactly 1 cycle): register the result and flags.
  - The first tx_start fires in the cycle after EXEC, so it lands 2 clocks after the rx_valid of the last B byte.
  - EXEC also retriggers led: led=1 and the blink counter is reloaded with BLINK_CYCLES.
- Arithmetic:
  - All ops are computed at WIDTH+1 bits.
  - SUB, SBC and CP compute A - B - borrow_in.
  - CP discards the difference and transmits A unchanged; its flags are those of the subtraction.
- Flag byte: {S, Z, 0, H, 0, PV, N, C}.
  - S = result[WIDTH-1].
  - Z = (result == 0).
  - H = carry/borrow out of bit 3 for arithmetic ops; 1 for AND; 0 for XOR and OR.
  - PV = signed overflow for arithmetic ops; even parity of result[7:0] for logic ops.
  - N = 1 for SUB, SBC and CP; 0 otherwise.
  - C = carry/borrow out of bit WIDTH-1 for arithmetic ops; 0 for logic ops.
- SEND: if !tx_busy, drive tx_data, pulse tx_start, go to SEND_WAIT.
- SEND_WAIT:
  - Ignore tx_busy in the first cycle (uart_tx busy latency).
  - Then wait for tx_busy=0.
  - Next byte: back to SEND. After the last byte: back to IDLE.
- Send order: WIDTH/8 result bytes LSB first, then the flag byte.
- Dropped bytes: rx_valid in EXEC, SEND or SEND_WAIT drops the byte and increments overrun_cnt, saturating at 0xFF.
- led deasserts when the blink counter reaches 0.
- Reset mid-frame or mid-send: immediate return to IDLE with tx_start=0. A byte already handed to uart_tx completes on the line and is not retransmitted.

Optional Feature:
- Macro: UART_ALU_BRIDGE_CHECKSUM_EN.
- When defined: one extra byte is transmitted after the flag byte, equal to the XOR of the opcode and every response byte sent before it. Error responses also carry it (0xEE becomes 0xEE followed by 0xEE^opcode; 0xE1 becomes 0xE1 followed by 0xE1^opcode).
- When undefined: no checksum byte, and no checksum register is present.

Decomposition:
- Package uart_alu_pkg holds:
  - op code localparams (OP_ADD..OP_CP);
  - the error codes ERR_BAD_OP=8'hEE and ERR_TIMEOUT=8'hE1;
  - FSM state encodings;
  - flag bit positions (FLAG_S=7, FLAG_Z=6, FLAG_H=4, FLAG_PV=2, FLAG_N=1, FLAG_C=0).
- One sub-module: z80_alu_w, a combinational WIDTH-parametrised ALU (a, b, op, cin -> result, flags). The bridge registers its outputs in EXEC.

Test Plan:
- WIDTH=8, frame 00 3A 2A -> tx bytes 64, 10; led rises on the EXEC cycle.
- WIDTH=8, frame 00 7F 01 -> 80, 94. Frame 02 10 10 -> 00, 42.
- WIDTH=16, frame 09 FF FF 00 00 (ADC, cin=1) -> 00, 00, 51. Frame 07 34 12 34 12 (CP) -> 34, 12, 42.
- Opcode 30 -> single byte EE, FSM back in IDLE. Frame 00 12 followed by TIMEOUT_CYCLES+10 idle clocks -> E1; the next valid frame is processed normally.
- 3 rx_valid strobes injected during SEND_WAIT -> overrun_cnt=3 and the response bytes are unchanged. Assert rst during the second tx byte -> tx_start=0, led=0, FSM in IDLE; a following frame completes correctly.
